qupls_decode_stage: RTL and testbench

- Parametrised multi-lane successor to the single-slot Qupls decoder. Decodes LANES instructions per group into decode_bus_t records behind a registered valid/ready stage with a 2-entry skid buffer.
- Adds per-lane valid masking, prefix-lane suppression, sync (fence 0xFF) serialisation with replay reporting, pipeline flush and a stall counter.
- Sits between instruction extract/align and rename.

---
 rtl/QuplsPkg.sv | 67 ++++++
 rtl/qupls_decode_lane.sv | 54 +++++
 rtl/qupls_decode_stage.sv | 161 ++++++++++++++++
 tb/tb_qupls_decode_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/QuplsPkg.sv
// rtl/QuplsPkg.sv - shared Qupls types, opcodes and decode helpers
package QuplsPkg;

  localparam int DEC_LANES = 4;

  localparam logic [6:0] OP_ADDI  = 7'h04;
  localparam logic [6:0] OP_CSR   = 7'h07;
  localparam logic [6:0] OP_LOAD  = 7'h20;
  localparam logic [6:0] OP_STORE = 7'h28;
  localparam logic [6:0] OP_PRED  = 7'h3D;
  localparam logic [6:0] OP_FENCE = 7'h3E;
  localparam logic [6:0] OP_PFX   = 7'h3F;

  typedef enum logic [1:0] {
    OM_APP    = 2'd0,
    OM_SUPER  = 2'd1,
    OM_HYPER  = 2'd2,
    OM_SECURE = 2'd3
  } operating_mode_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [47:0] ins;
  } ex_instruction_t;

  typedef struct packed {
    logic        v;
    logic        pfx;
    logic        alu;
    logic        mem;
    logic        load;
    logic        store;
    logic        fence;
    logic        sync;
    logic        pred;
    logic        predz;
    logic        csr;
    logic        priv_fault;
    logic [6:0]  opcode;
    logic [6:0]  rt;
    logic [6:0]  ra;
    logic [6:0]  rb;
    logic [6:0]  rc;
    logic [63:0] imm;
    logic [31:0] pc;
  } decode_bus_t;

  typedef struct packed {
    logic                            v;
    logic                            sync;
    decode_bus_t [DEC_LANES-1:0]     lane;
  } decode_group_t;

  typedef enum logic {
    DS_RUN       = 1'b0,
    DS_SYNC_WAIT = 1'b1
  } decode_stage_state_t;

  // A prefix supplies the upper 41 bits; otherwise the 23-bit field is sign-extended.
  function automatic logic [63:0] decode_imm(input logic [47:0] ins, input logic [47:0] prev);
    if (prev[6:0] == OP_PFX)
      decode_imm = {prev[47:7], ins[47:25]};
    else
      decode_imm = {{41{ins[47]}}, ins[47:25]};
  endfunction

endpackage

// File: rtl/qupls_decode_lane.sv
// rtl/qupls_decode_lane.sv - combinational single-lane instruction decode
module qupls_decode_lane
  import QuplsPkg::*;
(
  input  operating_mode_t om,
  input  logic            lane_v,
  input  ex_instruction_t instr,
  input  logic [47:0]     prev_ins,
  input  logic [3:0]      regx,
  output decode_bus_t     db
);

  logic [47:0] ins;
  logic [6:0]  op;
  logic        is_pfx;
  logic        is_load;
  logic        is_store;
  logic        is_fence;
  logic        is_csr;

  assign ins = instr.ins;
  assign op  = ins[6:0];

  always_comb begin
    is_pfx   = (op == OP_PFX);
    is_load  = (op == OP_LOAD);
    is_store = (op == OP_STORE);
    is_fence = (op == OP_FENCE);
    is_csr   = (op == OP_CSR);

    db            = '0;
    db.v          = lane_v & ~is_pfx;
    db.pfx        = is_pfx;
    db.alu        = (op == OP_ADDI);
    db.load       = is_load;
    db.store      = is_store;
    db.mem        = is_load | is_store;
    db.fence      = is_fence;
    db.sync       = is_fence & (ins[15:8] == 8'hFF);
    db.pred       = (op == OP_PRED);
    db.predz      = ins[39];
    db.csr        = is_csr;
    // CSR access from application mode traps later in the pipe.
    db.priv_fault = is_csr & (om == OM_APP);
    db.opcode     = op;
    db.rt         = {regx[0], ins[12:7]};
    db.ra         = {regx[1], ins[18:13]};
    db.rb         = {regx[2], ins[24:19]};
    db.rc         = {regx[3], ins[30:25]};
    db.imm        = decode_imm(ins, prev_ins);
    db.pc         = instr.pc;
  end

endmodule

// File: rtl/qupls_decode_stage.sv
// rtl/qupls_decode_stage.sv - multi-lane decode stage with skid buffer and sync serialisation
module qupls_decode_stage
  import QuplsPkg::*;
#(
  parameter int  LANES = 4,
  parameter int  SKID  = 1,
  parameter int  CNTW  = 16,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  operating_mode_t             om,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES-1:0]            in_lane_v,
  input  ex_instruction_t [LANES-1:0] instr,
  input  logic [LANES-1:0][3:0]       regx,
  input  logic                        rob_empty,
  output logic                        out_valid,
  input  logic                        out_ready,
  output decode_bus_t [LANES-1:0]     dbo,
  output logic                        replay_valid,
  output logic [LW-1:0]               replay_lane,
  output logic                        sync_wait,
  output logic [CNTW-1:0]             stall_cnt
);

  typedef struct packed {
    logic                    v;
    logic                    sync;
    decode_bus_t [LANES-1:0] lane;
  } group_t;

  decode_bus_t [LANES-1:0] lane_db;
  group_t                  dec_grp;
  group_t                  out_q;
  group_t                  skid_q;
  decode_stage_state_t     state;
  logic                    sync_done;
  logic                    found;
  logic                    replay_need;
  logic [LW-1:0]           sync_lane;
  logic                    xfer;
  logic                    out_free;
  logic                    accept;

  // Prefix folding only needs the preceding lane's instruction word.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [47:0] prev_ins;
    if (i == 0) begin : g_first
      assign prev_ins = '0;
    end else begin : g_rest
      assign prev_ins = instr[i-1].ins;
    end

    qupls_decode_lane u_lane (
      .om       (om),
      .lane_v   (in_lane_v[i]),
      .instr    (instr[i]),
      .prev_ins (prev_ins),
      .regx     (regx[i]),
      .db       (lane_db[i])
    );
  end

  // Everything after the first valid sync lane is squashed and must be refetched.
  always_comb begin
    dec_grp     = '0;
    dec_grp.v   = 1'b1;
    found       = 1'b0;
    replay_need = 1'b0;
    sync_lane   = '0;
    for (int i = 0; i < LANES; i++) begin
      dec_grp.lane[i] = lane_db[i];
      if (found) begin
        dec_grp.lane[i].v = 1'b0;
        replay_need       = replay_need | in_lane_v[i];
      end else if (in_lane_v[i] && lane_db[i].sync) begin
        found     = 1'b1;
        sync_lane = LW'(i);
      end
    end
    dec_grp.sync = found;
  end

  assign xfer     = out_q.v & out_ready;
  assign out_free = xfer | ~out_q.v;

  if (SKID != 0) begin : g_rdy_skid
    assign in_ready = ~skid_q.v & (state == DS_RUN);
  end else begin : g_rdy_reg
    assign in_ready = out_free & (state == DS_RUN);
  end

  assign accept    = in_valid & in_ready & ~flush;
  assign out_valid = out_q.v;
  assign dbo       = out_q.lane;
  assign sync_wait = (state == DS_SYNC_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      state        <= DS_RUN;
      sync_done    <= 1'b0;
      replay_valid <= 1'b0;
      replay_lane  <= '0;
      stall_cnt    <= '0;
    end else begin
      if (out_q.v && !out_ready && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNTW'(1);

      if (flush) begin
        out_q.v      <= 1'b0;
        skid_q.v     <= 1'b0;
        state        <= DS_RUN;
        sync_done    <= 1'b0;
        replay_valid <= 1'b0;
      end else begin
        replay_valid <= accept & dec_grp.sync & replay_need;
        if (accept && dec_grp.sync && replay_need)
          replay_lane <= sync_lane + LW'(1);

        // Skid entry is older than any new input, so it always drains first.
        if (out_free) begin
          if (skid_q.v) begin
            out_q <= skid_q;
            if (accept)
              skid_q <= dec_grp;
            else
              skid_q.v <= 1'b0;
          end else if (accept) begin
            out_q <= dec_grp;
          end else begin
            out_q.v <= 1'b0;
          end
        end else if (accept) begin
          skid_q <= dec_grp;
        end

        case (state)
          DS_RUN: begin
            if (accept && dec_grp.sync)
              state <= DS_SYNC_WAIT;
          end
          DS_SYNC_WAIT: begin
            if (xfer && out_q.sync)
              sync_done <= 1'b1;
            if (sync_done && rob_empty) begin
              state     <= DS_RUN;
              sync_done <= 1'b0;
            end
          end
          default: state <= DS_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qupls_decode_stage.sv
// tb/tb_qupls_decode_stage.sv - directed self-checking bench for qupls_decode_stage
module tb_qupls_decode_stage;
  import QuplsPkg::*;

  localparam int LANES = 4;
  localparam int CNTW  = 4;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        flush;
  operating_mode_t             om;
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES-1:0]            in_lane_v;
  ex_instruction_t [LANES-1:0] instr;
  logic [LANES-1:0][3:0]       regx;
  logic                        rob_empty;
  logic                        out_valid;
  logic                        out_ready;
  decode_bus_t [LANES-1:0]     dbo;
  logic                        replay_valid;
  logic [1:0]                  replay_lane;
  logic                        sync_wait;
  logic [CNTW-1:0]             stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  qupls_decode_stage #(.LANES(LANES), .SKID(1), .CNTW(CNTW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .om           (om),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_lane_v    (in_lane_v),
    .instr        (instr),
    .regx         (regx),
    .rob_empty    (rob_empty),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .dbo          (dbo),
    .replay_valid (replay_valid),
    .replay_lane  (replay_lane),
    .sync_wait    (sync_wait),
    .stall_cnt    (stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] f_addi(input logic [5:0] rt, input logic [22:0] imm);
    return {imm, 6'd0, 6'd0, rt, OP_ADDI};
  endfunction

  function automatic logic [47:0] f_fence_ff();
    return {32'd0, 8'hFF, 1'b0, OP_FENCE};
  endfunction

  function automatic logic [47:0] f_simple(input logic [6:0] op);
    return {41'd0, op};
  endfunction

  task automatic set_grp(input logic [22:0] base);
    for (int i = 0; i < LANES; i++) begin
      instr[i].pc  = 32'h2000 + 32'(4 * i);
      instr[i].ins = f_addi(6'd1, base + 23'(i));
    end
    in_lane_v = 4'hF;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    om        = OM_APP;
    in_valid  = 1'b0;
    in_lane_v = '0;
    instr     = '0;
    regx      = '0;
    rob_empty = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();

    chk("rst_out_valid", out_valid, 0);
    chk("rst_dbo", |dbo, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_sync_wait", sync_wait, 0);
    chk("rst_replay", replay_valid, 0);
    rst = 1'b0;

    // Back-to-back groups with the consumer always ready.
    regx[1] = 4'b0001;
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < LANES; i++)
        instr[i] = '{pc: 32'h100 + 32'(16 * g + 4 * i), ins: f_addi(6'd5, 23'(16 * g + i))};
      in_valid  = 1'b1;
      in_lane_v = 4'hF;
      step();
      chk("b2b_valid", out_valid, 1);
      chk("b2b_imm0", dbo[0].imm, 64'(16 * g));
      chk("b2b_imm3", dbo[3].imm, 64'(16 * g + 3));
      chk("b2b_pc2", dbo[2].pc, 64'(32'h100 + 16 * g + 8));
      chk("b2b_rdy", in_ready, 1);
    end
    chk("b2b_rt1_regx", dbo[1].rt, 7'h45);
    chk("b2b_alu", dbo[1].alu, 1);
    regx     = '0;
    in_valid = 1'b0;
    step();
    chk("b2b_drain", out_valid, 0);
    chk("b2b_stall", stall_cnt, 0);

    // Backpressure: A held, B captured in skid, C waits until release.
    out_ready = 1'b0;
    set_grp(23'h100);
    in_valid = 1'b1;
    step();
    chk("bp_a_out", dbo[0].imm, 64'h100);
    chk("bp_a_rdy", in_ready, 1);
    set_grp(23'h200);
    step();
    chk("bp_hold1", dbo[0].imm, 64'h100);
    chk("bp_skid_full", in_ready, 0);
    set_grp(23'h300);
    step();
    step();
    chk("bp_hold3", dbo[3].imm, 64'h103);
    chk("bp_stall3", stall_cnt, 3);
    out_ready = 1'b1;
    step();
    chk("bp_b_out", dbo[0].imm, 64'h200);
    chk("bp_b_valid", out_valid, 1);
    chk("bp_rdy_back", in_ready, 1);
    step();
    chk("bp_c_out", dbo[0].imm, 64'h300);
    in_valid = 1'b0;
    step();
    chk("bp_empty", out_valid, 0);
    chk("bp_stall_keep", stall_cnt, 3);

    // Sync in lane 1 with all lanes valid.
    instr[0].ins = {8'd0, 1'b1, 32'd0, OP_PRED};
    instr[1].ins = f_fence_ff();
    instr[2].ins = f_simple(OP_LOAD);
    instr[3].ins = f_addi(6'd2, 23'h7);
    in_lane_v = 4'hF;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    rob_empty = 1'b1;
    step();
    chk("sync_flag1", dbo[1].sync, 1);
    chk("sync_lane_v", {dbo[3].v, dbo[2].v, dbo[1].v, dbo[0].v}, 4'b0011);
    chk("sync_pred", {dbo[0].pred, dbo[0].predz}, 2'b11);
    chk("sync_mem2", dbo[2].mem, 1);
    chk("sync_replay_v", replay_valid, 1);
    chk("sync_replay_lane", replay_lane, 2);
    chk("sync_wait_set", sync_wait, 1);
    chk("sync_rdy0", in_ready, 0);
    in_valid = 1'b0;
    step();
    chk("sync_pulse_end", replay_valid, 0);
    chk("sync_early_rob", sync_wait, 1);
    out_ready = 1'b1;
    step();
    chk("sync_xfer", out_valid, 0);
    chk("sync_wait_xfer", sync_wait, 1);
    rob_empty = 1'b0;
    step();
    chk("sync_wait_rob0", sync_wait, 1);
    rob_empty = 1'b1;
    step();
    chk("sync_release", sync_wait, 0);
    chk("sync_rdy1", in_ready, 1);

    // Sync in the last lane: no replay.
    set_grp(23'h10);
    instr[3].ins = f_fence_ff();
    in_valid = 1'b1;
    step();
    chk("sync_last_replay", replay_valid, 0);
    chk("sync_last_flag", dbo[3].sync, 1);
    chk("sync_last_wait", sync_wait, 1);
    in_valid = 1'b0;
    step();
    step();
    chk("sync_last_release", sync_wait, 0);
    rob_empty = 1'b0;

    // Prefix in lane 0 folds into lane 1's immediate.
    instr[0].ins = {41'h0ABCDEF0123, OP_PFX};
    instr[1].ins = f_addi(6'd3, 23'h12345);
    instr[2].ins = f_addi(6'd4, 23'h7FFFFF);
    instr[3].ins = f_simple(OP_CSR);
    in_lane_v = 4'hF;
    in_valid  = 1'b1;
    step();
    chk("pfx_v0", dbo[0].v, 0);
    chk("pfx_flag0", dbo[0].pfx, 1);
    chk("pfx_v1", dbo[1].v, 1);
    chk("pfx_imm1", dbo[1].imm, {41'h0ABCDEF0123, 23'h12345});
    chk("pfx_sext2", dbo[2].imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pfx_priv3", dbo[3].priv_fault, 1);

    // Group with no valid lanes still occupies a slot.
    in_lane_v = 4'h0;
    step();
    chk("empty_valid", out_valid, 1);
    chk("empty_lanes", {dbo[3].v, dbo[2].v, dbo[1].v, dbo[0].v}, 0);
    in_valid = 1'b0;
    step();

    // Flush with output valid, skid full and input pending.
    out_ready = 1'b0;
    set_grp(23'h400);
    in_valid = 1'b1;
    step();
    chk("fl_f1", dbo[0].imm, 64'h400);
    set_grp(23'h500);
    step();
    chk("fl_skid_full", in_ready, 0);
    set_grp(23'h600);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_run", sync_wait, 0);
    chk("fl_stall_kept", stall_cnt, 6);
    out_ready = 1'b1;
    step();
    chk("fl_skid_gone", out_valid, 0);
    set_grp(23'h700);
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_input_drop", out_valid, 0);
    step();
    chk("fl_input_drop2", out_valid, 0);

    // Saturation of the stall counter, then reset mid-stall.
    out_ready = 1'b0;
    set_grp(23'h800);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat ((1 << CNTW) + 5) step();
    chk("sat_cnt", stall_cnt, 15);
    step();
    chk("sat_hold", stall_cnt, 15);
    rst = 1'b1;
    step();
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_dbo", |dbo, 0);
    chk("rst2_stall", stall_cnt, 0);
    chk("rst2_replay_lane", replay_lane, 0);
    chk("rst2_sync_wait", sync_wait, 0);
    chk("rst2_in_ready", in_ready, 1);
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
